regfile_multiport_sb: RTL and testbench

//  Parametrised integer register file for the RISC-V pipeline, next generation of the

---
 rtl/regfile_multiport_sb_if.sv | 32 +++
 rtl/regfile_multiport_sb.sv | 71 +++++++
 tb/tb_regfile_multiport_sb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_sb_if.sv
// Bundles the read, write-back and issue signals of the multiport register file.
// The master drives addresses, writes and issues; the slave returns read data and busy flags.
interface regfile_multiport_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_busy;
    logic                  we0;
    logic [AW-1:0]         rd0;
    logic [XLEN-1:0]       wd0;
    logic                  we1;
    logic [AW-1:0]         rd1;
    logic [XLEN-1:0]       wd1;
    logic                  issue_vld;
    logic [AW-1:0]         issue_rd;
    logic                  busy_any;

    modport master (
        output rs_addr, we0, rd0, wd0, we1, rd1, wd1, issue_vld, issue_rd,
        input  rs_data, rs_busy, busy_any
    );

    modport slave (
        input  rs_addr, we0, rd0, wd0, we1, rd1, wd1, issue_vld, issue_rd,
        output rs_data, rs_busy, busy_any
    );
endinterface

// File: rtl/regfile_multiport_sb.sv
// Dual-write, N-read integer register file with write-to-read bypass and a per-register
// busy scoreboard; x0 reads as zero and is never busy.
module regfile_multiport_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input logic                  clk,
    input logic                  rst,
    regfile_multiport_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr0;
    logic             wr1;

    assign wr0 = bus.we0 && (bus.rd0 != '0);
    assign wr1 = bus.we1 && (bus.rd1 != '0);

    // Writes retire the producer; a same-cycle issue names a newer producer and wins.
    always_comb begin
        busy_nxt = busy;
        if (wr0) busy_nxt[bus.rd0] = 1'b0;
        if (wr1) busy_nxt[bus.rd1] = 1'b0;
        if (bus.issue_vld && (bus.issue_rd != '0)) busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Lane 1 is assigned last so it overrides lane 0 on an address conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            busy <= '0;
        end else begin
            if (wr0) regs[bus.rd0] <= bus.wd0;
            if (wr1) regs[bus.rd1] <= bus.wd1;
            busy <= busy_nxt;
        end
    end

    always_comb begin : rd_mux
        logic [AW-1:0] a;
        logic          hit0;
        logic          hit1;
        a           = '0;
        hit0        = 1'b0;
        hit1        = 1'b0;
        bus.rs_data = '0;
        bus.rs_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            a    = bus.rs_addr[i*AW +: AW];
            hit0 = wr0 && (bus.rd0 == a);
            hit1 = wr1 && (bus.rd1 == a);
            if (a == '0)
                bus.rs_data[i*XLEN +: XLEN] = '0;
            else if (hit1)
                bus.rs_data[i*XLEN +: XLEN] = bus.wd1;
            else if (hit0)
                bus.rs_data[i*XLEN +: XLEN] = bus.wd0;
            else
                bus.rs_data[i*XLEN +: XLEN] = regs[a];
            // A bypassed operand is available now, so it is not reported busy.
            bus.rs_busy[i] = busy[a] & ~(hit0 | hit1);
        end
    end

    assign bus.busy_any = |busy;
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Randomised and directed bench for regfile_multiport_sb against an array-based reference model.
module tb_regfile_multiport_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    regfile_multiport_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

    regfile_multiport_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (bus.we1 && int'(bus.rd1) == a) return bus.wd1;
        if (bus.we0 && int'(bus.rd0) == a) return bus.wd0;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (bus.we1 && int'(bus.rd1) == a) return 1'b0;
        if (bus.we0 && int'(bus.rd0) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int k = 0; k < NREGS; k++) r |= m_busy[k];
        return r;
    endfunction

    // Apply the clock-edge rules of the register file to the model.
    function automatic void commit();
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            if (bus.we0 && bus.rd0 != 0) begin m_regs[bus.rd0] = bus.wd0; m_busy[bus.rd0] = 1'b0; end
            if (bus.we1 && bus.rd1 != 0) begin m_regs[bus.rd1] = bus.wd1; m_busy[bus.rd1] = 1'b0; end
            if (bus.issue_vld && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        bus.we0 = 0; bus.rd0 = '0; bus.wd0 = '0;
        bus.we1 = 0; bus.rd1 = '0; bus.wd1 = '0;
        bus.issue_vld = 0; bus.issue_rd = '0;
    endtask

    task automatic set_addr(input int a0, input int a1);
        bus.rs_addr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); set_addr(0, 0);
        tick();
        rst = 0;
        for (int a = 0; a < NREGS; a++) begin
            set_addr(a, NREGS - 1 - a);
            for (int p = 0; p < NREAD; p++) begin
                total++;
                if (bus.rs_data[p*XLEN +: XLEN] !== '0) $display("FAIL reset_data a=%0d p=%0d got %h want 0", a, p, bus.rs_data[p*XLEN +: XLEN]);
                else passed++;
                total++;
                if (bus.rs_busy[p] !== 1'b0) $display("FAIL reset_busy a=%0d p=%0d got %b want 0", a, p, bus.rs_busy[p]);
                else passed++;
            end
            total++;
            if (bus.busy_any !== 1'b0) $display("FAIL reset_busy_any got %b want 0", bus.busy_any);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        idle();
        bus.we0 = 1; bus.rd0 = 5'd2; bus.wd0 = 32'h1;
        set_addr(2, 3);
        total++;
        if (bus.rs_data[31:0] !== 32'h1) $display("FAIL bypass_lane0 got %h want 00000001", bus.rs_data[31:0]);
        else passed++;
        total++;
        if (bus.rs_data[63:32] !== 32'h0) $display("FAIL bypass_other_reg got %h want 0", bus.rs_data[63:32]);
        else passed++;
        tick();
        idle(); set_addr(2, 2);
        total++;
        if (bus.rs_data[31:0] !== 32'h1) $display("FAIL stored_lane0 got %h want 00000001", bus.rs_data[31:0]);
        else passed++;
        total++;
        if (bus.rs_data[63:32] !== 32'h1) $display("FAIL stored_lane0_p1 got %h want 00000001", bus.rs_data[63:32]);
        else passed++;
    endtask

    task automatic test_lane_conflict();
        idle();
        bus.we0 = 1; bus.rd0 = 5'd5; bus.wd0 = 32'hAAAA_AAAA;
        bus.we1 = 1; bus.rd1 = 5'd5; bus.wd1 = 32'h5555_5555;
        set_addr(5, 5);
        total++;
        if (bus.rs_data[31:0] !== 32'h5555_5555) $display("FAIL conflict_bypass got %h want 55555555", bus.rs_data[31:0]);
        else passed++;
        tick();
        idle(); set_addr(5, 2);
        total++;
        if (bus.rs_data[31:0] !== 32'h5555_5555) $display("FAIL conflict_stored got %h want 55555555", bus.rs_data[31:0]);
        else passed++;
        total++;
        if (bus.rs_data[63:32] !== 32'h1) $display("FAIL conflict_neighbour got %h want 00000001", bus.rs_data[63:32]);
        else passed++;
    endtask

    task automatic test_x0();
        idle();
        bus.we0 = 1; bus.rd0 = '0; bus.wd0 = 32'hFFFF_FFFF;
        bus.we1 = 1; bus.rd1 = '0; bus.wd1 = 32'hDEAD_BEEF;
        bus.issue_vld = 1; bus.issue_rd = '0;
        set_addr(0, 0);
        total++;
        if (bus.rs_data[31:0] !== 32'h0) $display("FAIL x0_bypass got %h want 0", bus.rs_data[31:0]);
        else passed++;
        tick();
        idle(); set_addr(0, 0);
        total++;
        if (bus.rs_data !== '0) $display("FAIL x0_stored got %h want 0", bus.rs_data);
        else passed++;
        total++;
        if (bus.rs_busy !== 2'b00) $display("FAIL x0_busy got %b want 00", bus.rs_busy);
        else passed++;
        total++;
        if (bus.busy_any !== 1'b0) $display("FAIL x0_busy_any got %b want 0", bus.busy_any);
        else passed++;
    endtask

    task automatic test_scoreboard();
        idle();
        bus.issue_vld = 1; bus.issue_rd = 5'd7;
        set_addr(7, 0);
        total++;
        if (bus.rs_busy[0] !== 1'b0) $display("FAIL sb_before_edge got %b want 0", bus.rs_busy[0]);
        else passed++;
        tick();
        idle(); set_addr(7, 0);
        total++;
        if (bus.rs_busy !== 2'b01) $display("FAIL sb_busy7 got %b want 01", bus.rs_busy);
        else passed++;
        total++;
        if (bus.busy_any !== 1'b1) $display("FAIL sb_busy_any_set got %b want 1", bus.busy_any);
        else passed++;
        bus.we1 = 1; bus.rd1 = 5'd7; bus.wd1 = 32'h1234;
        set_addr(7, 7);
        total++;
        if (bus.rs_busy !== 2'b00) $display("FAIL sb_bypass_busy got %b want 00", bus.rs_busy);
        else passed++;
        total++;
        if (bus.rs_data[31:0] !== 32'h1234) $display("FAIL sb_bypass_data got %h want 00001234", bus.rs_data[31:0]);
        else passed++;
        total++;
        if (bus.busy_any !== 1'b1) $display("FAIL sb_busy_any_no_bypass got %b want 1", bus.busy_any);
        else passed++;
        tick();
        idle(); set_addr(7, 0);
        total++;
        if (bus.busy_any !== 1'b0) $display("FAIL sb_busy_any_clear got %b want 0", bus.busy_any);
        else passed++;
        total++;
        if (bus.rs_data[31:0] !== 32'h1234) $display("FAIL sb_stored got %h want 00001234", bus.rs_data[31:0]);
        else passed++;
    endtask

    task automatic test_issue_write_same();
        idle();
        bus.issue_vld = 1; bus.issue_rd = 5'd9;
        bus.we0 = 1; bus.rd0 = 5'd9; bus.wd0 = 32'hCAFE_0009;
        tick();
        idle(); set_addr(9, 0);
        total++;
        if (bus.rs_busy[0] !== 1'b1) $display("FAIL set_wins_busy got %b want 1", bus.rs_busy[0]);
        else passed++;
        total++;
        if (bus.rs_data[31:0] !== 32'hCAFE_0009) $display("FAIL set_wins_data got %h want cafe0009", bus.rs_data[31:0]);
        else passed++;
        total++;
        if (bus.busy_any !== 1'b1) $display("FAIL set_wins_any got %b want 1", bus.busy_any);
        else passed++;
        rst = 1;
        bus.issue_vld = 1; bus.issue_rd = 5'd10;
        tick();
        rst = 0; idle();
        for (int a = 0; a < NREGS; a += 2) begin
            set_addr(a, a + 1);
            total++;
            if (bus.rs_data !== '0 || bus.rs_busy !== 2'b00 || bus.busy_any !== 1'b0)
                $display("FAIL flush a=%0d got data=%h busy=%b any=%b want all 0", a, bus.rs_data, bus.rs_busy, bus.busy_any);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.we0 = !rst && $urandom_range(0, 1) == 1;
            bus.rd0 = AW'($urandom_range(0, 7));
            bus.wd0 = $urandom;
            bus.we1 = !rst && $urandom_range(0, 1) == 1;
            bus.rd1 = AW'($urandom_range(0, 7));
            bus.wd1 = $urandom;
            bus.issue_vld = $urandom_range(0, 2) != 0;
            bus.issue_rd  = AW'($urandom_range(0, 9));
            set_addr($urandom_range(0, 9), $urandom_range(0, NREGS - 1));
            for (int p = 0; p < NREAD; p++) begin
                int a;
                a = int'(bus.rs_addr[p*AW +: AW]);
                total++;
                if (bus.rs_data[p*XLEN +: XLEN] !== exp_data(a))
                    $display("FAIL rand_data c=%0d p=%0d a=%0d got %h want %h", c, p, a, bus.rs_data[p*XLEN +: XLEN], exp_data(a));
                else passed++;
                total++;
                if (bus.rs_busy[p] !== exp_busy(a))
                    $display("FAIL rand_busy c=%0d p=%0d a=%0d got %b want %b", c, p, a, bus.rs_busy[p], exp_busy(a));
                else passed++;
            end
            total++;
            if (bus.busy_any !== exp_any()) $display("FAIL rand_busy_any c=%0d got %b want %b", c, bus.busy_any, exp_any());
            else passed++;
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        for (int k = 0; k < NREGS; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_lane_conflict();
        test_x0();
        test_scoreboard();
        test_issue_write_same();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
